// File: rtl/ble_pkg.sv
// Shared constants, FSM state encoding and command layout for the BLE packet
// receiver. The packet checksum is compiled in only when BLE_RX_CHECKSUM_EN
// is defined (see ble_packet_rx).
package ble_pkg;

  localparam logic [7:0] START_BYTE  = 8'h21;
  localparam logic [7:0] TYPE_BUTTON = 8'h42;
  localparam logic [7:0] TYPE_COLOR  = 8'h43;

  // Default command geometry (4 payload bytes); the receiver builds its own
  // entry type from its MAX_PAYLOAD parameter with the same field order.
  localparam int CMD_MAX_PAYLOAD = 4;
  localparam int CMD_LEN_W       = $clog2(CMD_MAX_PAYLOAD + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TYPE    = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CHECK   = 2'd3
  } ble_state_t;

  typedef struct packed {
    logic [7:0]                   pkt_type;
    logic [CMD_LEN_W-1:0]         len;
    logic [8*CMD_MAX_PAYLOAD-1:0] payload;
  } ble_cmd_t;

  // Payload length for a packet type; 0 marks an unknown type.
  function automatic logic [7:0] payload_len(input logic [7:0] pkt_type);
    case (pkt_type)
      TYPE_BUTTON: payload_len = 8'd2;
      TYPE_COLOR:  payload_len = 8'd3;
      default:     payload_len = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/ble_cmd_fifo.sv
// Synchronous show-ahead FIFO for decoded commands. The head entry is always
// visible on head_out while not empty. A push into a full FIFO is accepted
// when a pop happens in the same cycle (the freed slot is the one written).
module ble_cmd_fifo #(
  parameter type entry_t = ble_pkg::ble_cmd_t,
  parameter int  DEPTH   = 8,
  parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             push_in,
  input  entry_t           push_data_in,
  input  logic             pop_in,
  output entry_t           head_out,
  output logic             full_out,
  output logic             empty_out,
  output logic [CNT_W-1:0] count_out
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full_out  = (count == CNT_W'(DEPTH));
  assign empty_out = (count == '0);
  assign count_out = count;
  assign head_out  = mem[rd_ptr];

  // Qualify the requests against occupancy.
  always_comb begin
    do_pop  = pop_in && !empty_out;
    do_push = push_in && (!full_out || do_pop);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data_in;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ble_packet_rx.sv
// BLE UART packet parser: START, TYPE, payload, checksum. Good packets are
// queued in a show-ahead command FIFO; checksum, timeout and overflow errors
// are reported as registered one-cycle pulses plus a saturating counter.
// Define BLE_RX_CHECKSUM_EN to verify the checksum byte (~sum of START, TYPE
// and payload); otherwise the checksum byte is consumed and ignored.
// state_out exposes the parser FSM state for debug.
//
// Handshake: the head command transfers on any rising edge where
// cmd_valid_out && cmd_ready_in; cmd_valid_out never depends on cmd_ready_in
// and head fields hold steady while valid is high and ready is low.
module ble_packet_rx
  import ble_pkg::*;
#(
  parameter int MAX_PAYLOAD    = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 74250
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic [7:0]                           byte_in,
  input  logic                                 byte_valid_in,
  input  logic                                 cmd_ready_in,
  output logic                                 cmd_valid_out,
  output logic [7:0]                           cmd_type_out,
  output logic [8*MAX_PAYLOAD-1:0]             cmd_payload_out,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0]     cmd_len_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count_out,
  output logic                                 err_checksum_out,
  output logic                                 err_timeout_out,
  output logic                                 err_overflow_out,
  output logic [7:0]                           err_count_out,
  output logic [1:0]                           state_out
);

  localparam int LEN_W = $clog2(MAX_PAYLOAD + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

  typedef struct packed {
    logic [7:0]               pkt_type;
    logic [LEN_W-1:0]         len;
    logic [8*MAX_PAYLOAD-1:0] payload;
  } cmd_t;

  ble_state_t               state;
  logic [7:0]               type_q;
  logic [LEN_W-1:0]         len_q;
  logic [LEN_W-1:0]         idx_q;
  logic [8*MAX_PAYLOAD-1:0] payload_q;
  logic [TMO_W-1:0]         tmo_cnt;
  logic                     err_timeout_q;
  logic                     err_overflow_q;
  logic [7:0]               err_count_q;

  logic                     chk_ok;
  logic                     good_pkt;
  logic                     ovf_evt;
  logic                     tmo_evt;
  logic                     err_any;
  logic                     pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  cmd_t                     push_data;
  cmd_t                     head;

`ifdef BLE_RX_CHECKSUM_EN
  logic [7:0]               sum_q;
  logic                     err_checksum_q;
  logic                     bad_evt;
`endif

  assign pop              = cmd_valid_out && cmd_ready_in;
  assign cmd_valid_out    = !fifo_empty;
  assign cmd_type_out     = head.pkt_type;
  assign cmd_len_out      = head.len;
  assign cmd_payload_out  = head.payload;
  assign err_timeout_out  = err_timeout_q;
  assign err_overflow_out = err_overflow_q;
  assign err_count_out    = err_count_q;
  assign state_out        = state;
`ifdef BLE_RX_CHECKSUM_EN
  assign err_checksum_out = err_checksum_q;
`else
  assign err_checksum_out = 1'b0;
`endif

  // Packet verdicts for the checksum byte and the inter-byte timeout.
  always_comb begin
`ifdef BLE_RX_CHECKSUM_EN
    chk_ok  = (byte_in == ~sum_q);
    bad_evt = (state == ST_CHECK) && byte_valid_in && !chk_ok;
`else
    chk_ok  = 1'b1;
`endif
    good_pkt = (state == ST_CHECK) && byte_valid_in && chk_ok;
    ovf_evt  = good_pkt && fifo_full && !pop;
    tmo_evt  = (state != ST_IDLE) && !byte_valid_in &&
               (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    err_any  = ovf_evt || tmo_evt;
`ifdef BLE_RX_CHECKSUM_EN
    err_any  = err_any || bad_evt;
`endif
    push_data          = '0;
    push_data.pkt_type = type_q;
    push_data.len      = len_q;
    push_data.payload  = payload_q;
  end

  // Parser FSM; advances only on byte strobes, falls back to IDLE on timeout.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state          <= ST_IDLE;
      type_q         <= '0;
      len_q          <= '0;
      idx_q          <= '0;
      payload_q      <= '0;
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
`ifdef BLE_RX_CHECKSUM_EN
      err_checksum_q <= 1'b0;
`endif
    end else begin
      err_timeout_q  <= 1'b0;
      err_overflow_q <= 1'b0;
`ifdef BLE_RX_CHECKSUM_EN
      err_checksum_q <= 1'b0;
`endif
      if (byte_valid_in) begin
        case (state)
          ST_IDLE: begin
            if (byte_in == START_BYTE) state <= ST_TYPE;
          end
          ST_TYPE: begin
            if (payload_len(byte_in) != 8'd0) begin
              type_q    <= byte_in;
              len_q     <= LEN_W'(payload_len(byte_in));
              idx_q     <= '0;
              payload_q <= '0;
              state     <= ST_PAYLOAD;
            end else if (byte_in != START_BYTE) begin
              state <= ST_IDLE;
            end
          end
          ST_PAYLOAD: begin
            payload_q[8*idx_q +: 8] <= byte_in;
            if (idx_q == len_q - LEN_W'(1)) state <= ST_CHECK;
            else idx_q <= idx_q + LEN_W'(1);
          end
          ST_CHECK: begin
            err_overflow_q <= ovf_evt;
`ifdef BLE_RX_CHECKSUM_EN
            err_checksum_q <= bad_evt;
`endif
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (tmo_evt) begin
        state         <= ST_IDLE;
        err_timeout_q <= 1'b1;
      end
    end
  end

`ifdef BLE_RX_CHECKSUM_EN
  // Running sum from START up to (not including) the checksum byte; a START
  // seen in TYPE restarts it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sum_q <= '0;
    end else if (byte_valid_in) begin
      case (state)
        ST_IDLE:    if (byte_in == START_BYTE) sum_q <= byte_in;
        ST_TYPE:    sum_q <= (byte_in == START_BYTE) ? byte_in : sum_q + byte_in;
        ST_PAYLOAD: sum_q <= sum_q + byte_in;
        default:    sum_q <= sum_q;
      endcase
    end
  end
`endif

  // Idle-cycle counter between bytes of a packet.
  always_ff @(posedge clk_in) begin
    if (rst_in || byte_valid_in || state == ST_IDLE || tmo_evt) tmo_cnt <= '0;
    else tmo_cnt <= tmo_cnt + TMO_W'(1);
  end

  // Saturating error counter; at most one error source fires per cycle.
  always_ff @(posedge clk_in) begin
    if (rst_in) err_count_q <= '0;
    else if (err_any && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
  end

  ble_cmd_fifo #(
    .entry_t (cmd_t),
    .DEPTH   (FIFO_DEPTH),
    .CNT_W   (CNT_W)
  ) u_fifo (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .push_in      (good_pkt),
    .push_data_in (push_data),
    .pop_in       (pop),
    .head_out     (head),
    .full_out     (fifo_full),
    .empty_out    (fifo_empty),
    .count_out    (fifo_count_out)
  );

endmodule

// File: tb/tb_ble_packet_rx.sv
// Directed bench for ble_packet_rx: decode, checksum, timeout, overflow,
// resync, back-to-back traffic, error saturation and reset flush.
module tb_ble_packet_rx;

  localparam int MAXP = 4;
  localparam int DEPTH = 8;
  localparam int TMO = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [7:0]  byte_in;
  logic        byte_valid_in;
  logic        cmd_ready_in;
  logic        cmd_valid_out;
  logic [7:0]  cmd_type_out;
  logic [31:0] cmd_payload_out;
  logic [2:0]  cmd_len_out;
  logic [3:0]  fifo_count_out;
  logic        err_checksum_out;
  logic        err_timeout_out;
  logic        err_overflow_out;
  logic [7:0]  err_count_out;
  logic [1:0]  state_out;

  int total = 0;
  int bad = 0;
  int exp_err = 0;
  logic err_seen;
  logic [42:0] exp_q[$];

  ble_packet_rx #(
    .MAX_PAYLOAD(MAXP), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .byte_in(byte_in),
    .byte_valid_in(byte_valid_in), .cmd_ready_in(cmd_ready_in),
    .cmd_valid_out(cmd_valid_out), .cmd_type_out(cmd_type_out),
    .cmd_payload_out(cmd_payload_out), .cmd_len_out(cmd_len_out),
    .fifo_count_out(fifo_count_out), .err_checksum_out(err_checksum_out),
    .err_timeout_out(err_timeout_out), .err_overflow_out(err_overflow_out),
    .err_count_out(err_count_out), .state_out(state_out)
  );

  // Clock and reset
  always #5 clk_in = ~clk_in;

  task automatic do_reset();
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    exp_err = 0;
    exp_q.delete();
  endtask

  // Drivers: called at a negedge, return at the next negedge.
  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_valid_in = 1'b1;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    err_seen = err_seen | err_checksum_out | err_timeout_out | err_overflow_out;
  endtask

  function automatic logic [7:0] csum(input logic [7:0] t, input logic [31:0] pl, input int n);
    logic [7:0] s;
    s = 8'h21 + t;
    for (int i = 0; i < n; i++) s = s + pl[8*i +: 8];
    return ~s;
  endfunction

  function automatic logic [42:0] mk(input logic [7:0] t, input logic [31:0] pl);
    return {t, (t == 8'h43) ? 3'd3 : 3'd2, pl};
  endfunction

  task automatic send_pkt(input logic [7:0] t, input logic [31:0] pl);
    int n;
    n = (t == 8'h43) ? 3 : 2;
    send(8'h21);
    send(t);
    for (int i = 0; i < n; i++) send(pl[8*i +: 8]);
    send(csum(t, pl, n));
  endtask

  task automatic pop_one();
    cmd_ready_in = 1'b1;
    @(negedge clk_in);
    cmd_ready_in = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (cmd_valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", cmd_valid_out); end
    total++; if (fifo_count_out !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", fifo_count_out); end
    total++; if (err_count_out !== 8'd0) begin bad++; $display("FAIL reset_errcnt got=%0d exp=0", err_count_out); end
    total++; if ({err_checksum_out, err_timeout_out, err_overflow_out} !== 3'b000) begin
      bad++; $display("FAIL reset_err_pulses got=%b exp=000", {err_checksum_out, err_timeout_out, err_overflow_out}); end
    total++; if (state_out !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_out); end
  endtask

  task automatic test_button();
    send(8'h21); send(8'h42); send(8'h35); send(8'h31); send(8'h36);
    total++; if (cmd_valid_out !== 1'b1) begin bad++; $display("FAIL button_valid got=%0b exp=1", cmd_valid_out); end
    total++; if ({cmd_type_out, cmd_len_out, cmd_payload_out} !== {8'h42, 3'd2, 32'h0000_3135}) begin
      bad++; $display("FAIL button_cmd got=%h/%0d/%h exp=42/2/00003135", cmd_type_out, cmd_len_out, cmd_payload_out); end
    total++; if (fifo_count_out !== 4'd1) begin bad++; $display("FAIL button_count got=%0d exp=1", fifo_count_out); end
    pop_one();
    total++; if (cmd_valid_out !== 1'b0 || fifo_count_out !== 4'd0) begin
      bad++; $display("FAIL button_pop got=%0b/%0d exp=0/0", cmd_valid_out, fifo_count_out); end
  endtask

  task automatic test_color();
    send(8'h21); send(8'h43); send(8'hFF); send(8'h00); send(8'h80); send(8'h1C);
    total++; if ({cmd_valid_out, cmd_type_out, cmd_len_out, cmd_payload_out} !== {1'b1, 8'h43, 3'd3, 32'h0080_00FF}) begin
      bad++; $display("FAIL color_cmd got=%0b/%h/%0d/%h exp=1/43/3/008000ff",
                      cmd_valid_out, cmd_type_out, cmd_len_out, cmd_payload_out); end
    pop_one();
  endtask

  task automatic test_checksum();
    send(8'h21); send(8'h42); send(8'h35); send(8'h31); send(8'h37);
`ifdef BLE_RX_CHECKSUM_EN
    exp_err++;
    total++; if (err_checksum_out !== 1'b1) begin bad++; $display("FAIL chk_pulse got=%0b exp=1", err_checksum_out); end
    total++; if (fifo_count_out !== 4'd0) begin bad++; $display("FAIL chk_drop got=%0d exp=0", fifo_count_out); end
    total++; if (err_count_out !== 8'(exp_err)) begin bad++; $display("FAIL chk_errcnt got=%0d exp=%0d", err_count_out, exp_err); end
    @(negedge clk_in);
    total++; if (err_checksum_out !== 1'b0) begin bad++; $display("FAIL chk_pulse_len got=%0b exp=0", err_checksum_out); end
`else
    total++; if (err_checksum_out !== 1'b0) begin bad++; $display("FAIL nochk_pulse got=%0b exp=0", err_checksum_out); end
    total++; if ({fifo_count_out, cmd_payload_out} !== {4'd1, 32'h0000_3135}) begin
      bad++; $display("FAIL nochk_push got=%0d/%h exp=1/00003135", fifo_count_out, cmd_payload_out); end
    total++; if (err_count_out !== 8'(exp_err)) begin bad++; $display("FAIL nochk_errcnt got=%0d exp=%0d", err_count_out, exp_err); end
    pop_one();
`endif
  endtask

  task automatic test_timeout();
    int first;
    int pulses;
    first = 0;
    pulses = 0;
    send(8'h21); send(8'h42); send(8'h35);
    for (int k = 1; k <= 3 * TMO; k++) begin
      @(negedge clk_in);
      if (err_timeout_out) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    exp_err++;
    total++; if (pulses != 1) begin bad++; $display("FAIL tmo_pulses got=%0d exp=1", pulses); end
    total++; if (first != TMO) begin bad++; $display("FAIL tmo_cycle got=%0d exp=%0d", first, TMO); end
    total++; if (state_out !== 2'd0) begin bad++; $display("FAIL tmo_state got=%0d exp=0", state_out); end
    total++; if (err_count_out !== 8'(exp_err)) begin bad++; $display("FAIL tmo_errcnt got=%0d exp=%0d", err_count_out, exp_err); end
    send_pkt(8'h42, 32'h0000_3135);
    total++; if ({fifo_count_out, cmd_type_out, cmd_payload_out} !== {4'd1, 8'h42, 32'h0000_3135}) begin
      bad++; $display("FAIL tmo_after got=%0d/%h/%h exp=1/42/00003135", fifo_count_out, cmd_type_out, cmd_payload_out); end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [31:0] pl;
    logic [42:0] got;
    cmd_ready_in = 1'b0;
    for (int i = 0; i < 9; i++) begin
      pl = {16'h0, 8'(8'h10 + i), 8'(8'hA0 + 3 * i)};
      send_pkt(8'h42, pl);
      if (i < DEPTH) exp_q.push_back(mk(8'h42, pl));
    end
    exp_err++;
    total++; if (fifo_count_out !== 4'd8) begin bad++; $display("FAIL ovf_count got=%0d exp=8", fifo_count_out); end
    total++; if (err_overflow_out !== 1'b1) begin bad++; $display("FAIL ovf_pulse got=%0b exp=1", err_overflow_out); end
    total++; if (err_count_out !== 8'(exp_err)) begin bad++; $display("FAIL ovf_errcnt got=%0d exp=%0d", err_count_out, exp_err); end
    @(negedge clk_in);
    total++; if (err_overflow_out !== 1'b0) begin bad++; $display("FAIL ovf_pulse_len got=%0b exp=0", err_overflow_out); end
    // Full FIFO, checksum byte lands together with a pop.
    pl = 32'h0077_6655;
    send(8'h21); send(8'h43); send(8'h55); send(8'h66); send(8'h77);
    got = {cmd_type_out, cmd_len_out, cmd_payload_out};
    total++; if (got !== exp_q[0]) begin bad++; $display("FAIL ovf_hold_head got=%h exp=%h", got, exp_q[0]); end
    byte_in = csum(8'h43, pl, 3);
    byte_valid_in = 1'b1;
    cmd_ready_in = 1'b1;
    @(negedge clk_in);
    byte_valid_in = 1'b0;
    cmd_ready_in = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(mk(8'h43, pl));
    total++; if (fifo_count_out !== 4'd8 || err_overflow_out !== 1'b0) begin
      bad++; $display("FAIL ovf_pop_push got=%0d/%0b exp=8/0", fifo_count_out, err_overflow_out); end
    // Drain at one pop per cycle.
    cmd_ready_in = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      got = {cmd_type_out, cmd_len_out, cmd_payload_out};
      total++; if (!cmd_valid_out || got !== exp_q[0]) begin
        bad++; $display("FAIL drain_%0d got=%0b/%h exp=1/%h", i, cmd_valid_out, got, exp_q[0]); end
      void'(exp_q.pop_front());
      @(negedge clk_in);
    end
    cmd_ready_in = 1'b0;
    total++; if (cmd_valid_out !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0b exp=0", cmd_valid_out); end
  endtask

  task automatic test_resync();
    err_seen = 1'b0;
    send(8'h21); send(8'h58);
    send(8'h21); send(8'h21); send(8'h42); send(8'h35); send(8'h31); send(8'h36);
    total++; if ({fifo_count_out, cmd_type_out, cmd_len_out, cmd_payload_out} !== {4'd1, 8'h42, 3'd2, 32'h0000_3135}) begin
      bad++; $display("FAIL resync_cmd got=%0d/%h/%0d/%h exp=1/42/2/00003135",
                      fifo_count_out, cmd_type_out, cmd_len_out, cmd_payload_out); end
    total++; if (err_seen !== 1'b0 || err_count_out !== 8'(exp_err)) begin
      bad++; $display("FAIL resync_err got=%0b/%0d exp=0/%0d", err_seen, err_count_out, exp_err); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    logic [42:0] got;
    send_pkt(8'h43, 32'h0003_0201);
    send_pkt(8'h42, 32'h0000_BEEF);
    total++; if (fifo_count_out !== 4'd2) begin bad++; $display("FAIL b2b_count got=%0d exp=2", fifo_count_out); end
    got = {cmd_type_out, cmd_len_out, cmd_payload_out};
    total++; if (got !== mk(8'h43, 32'h0003_0201)) begin bad++; $display("FAIL b2b_first got=%h exp=%h", got, mk(8'h43, 32'h0003_0201)); end
    pop_one();
    got = {cmd_type_out, cmd_len_out, cmd_payload_out};
    total++; if (got !== mk(8'h42, 32'h0000_BEEF)) begin bad++; $display("FAIL b2b_second got=%h exp=%h", got, mk(8'h42, 32'h0000_BEEF)); end
    pop_one();
  endtask

  task automatic test_saturation();
    cmd_ready_in = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_pkt(8'h42, 32'(i));
    for (int i = 0; i < 256; i++) begin
      send_pkt(8'h42, 32'h0000_0101);
      if (exp_err < 255) exp_err++;
      total++; if (err_count_out !== 8'(exp_err)) begin
        bad++; $display("FAIL sat_%0d got=%0d exp=%0d", i, err_count_out, exp_err); end
    end
  endtask

  task automatic test_reset_flush();
    send(8'h21); send(8'h42); send(8'h35);
    do_reset();
    total++; if ({cmd_valid_out, fifo_count_out, err_count_out, state_out} !== {1'b0, 4'd0, 8'd0, 2'd0}) begin
      bad++; $display("FAIL flush got=%0b/%0d/%0d/%0d exp=0/0/0/0", cmd_valid_out, fifo_count_out, err_count_out, state_out); end
    send(8'h31); send(8'h36);
    total++; if (fifo_count_out !== 4'd0 || state_out !== 2'd0) begin
      bad++; $display("FAIL flush_midpkt got=%0d/%0d exp=0/0", fifo_count_out, state_out); end
    send_pkt(8'h43, 32'h0012_3456);
    total++; if ({fifo_count_out, cmd_payload_out} !== {4'd1, 32'h0012_3456}) begin
      bad++; $display("FAIL flush_after got=%0d/%h exp=1/00123456", fifo_count_out, cmd_payload_out); end
  endtask

  initial begin
    byte_in = 8'h00;
    byte_valid_in = 1'b0;
    cmd_ready_in = 1'b0;
    err_seen = 1'b0;
    @(negedge clk_in);
    do_reset();
    test_reset();
    test_button();
    test_color();
    test_checksum();
    test_timeout();
    test_overflow();
    test_resync();
    test_back_to_back();
    test_saturation();
    test_reset_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
